// File: rtl/wb_fir_bridge.sv
// wb_fir_bridge: Wishbone-classic slave that turns bus accesses into fir
// AXI-Lite register reads/writes, X stream pushes and Y stream pops.
// ss_tlast is generated locally from the data length snooped on AXI-Lite
// writes to LEN_OFFSET.
// Optional feature macro: WB_FIR_STATUS_EN (read-only status word at 0x88).
module wb_fir_bridge #(
    parameter int unsigned           pADDR_WIDTH = 12,
    parameter int unsigned           pDATA_WIDTH = 32,
    parameter logic [31:0]           BASE_ADDR   = 32'h3000_0000,
    parameter logic [pADDR_WIDTH-1:0] LEN_OFFSET = 12'h010
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    // Wishbone slave
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [pDATA_WIDTH-1:0] wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [pDATA_WIDTH-1:0] wbs_dat_o,
    // AXI-Lite write
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    // AXI-Lite read
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    // stream into fir
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready,
    // stream out of fir
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready
);

    typedef enum logic [2:0] {IDLE, LW, LAR, LR, SSP, SMP, ACK} state_t;

    state_t                 state_q, state_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic [pADDR_WIDTH-1:0] addr_q, addr_d;
    logic [pDATA_WIDTH-1:0] wd_q, wd_d;
    logic [pDATA_WIDTH-1:0] rd_q, rd_d;
    logic [pDATA_WIDTH-1:0] len_q, len_d;
    logic [31:0]            xcnt_q, xcnt_d;

    logic       req;
    logic       base_hit;
    logic [7:0] off;
    logic       last_x;

    // Byte selects and the fir's own tlast carry no information for us.
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_sel_i, sm_tlast};

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign base_hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off      = wbs_adr_i[7:0];
    // 33-bit compare so a zero length can never match, even when xcnt wraps.
    assign last_x   = (({1'b0, xcnt_q} + 33'd1) == 33'(len_q));

    // Next-state and datapath: one transaction is carried from IDLE to ACK.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        rd_d      = rd_q;
        len_d     = len_q;
        xcnt_d    = xcnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = wbs_adr_i[pADDR_WIDTH-1:0];
                    wd_d    = wbs_dat_i;
                    rd_d    = '0;
                    state_d = ACK;
                    if (base_hit) begin
                        if (!off[7]) begin
                            if (wbs_we_i) begin
                                state_d   = LW;
                                awvalid_d = 1'b1;
                                wvalid_d  = 1'b1;
                            end else begin
                                state_d = LAR;
                            end
                        end else if (off == 8'h80) begin
                            if (wbs_we_i) state_d = SSP;
                        end else if (off == 8'h84) begin
                            if (!wbs_we_i) state_d = SMP;
                        end
`ifdef WB_FIR_STATUS_EN
                        else if (off == 8'h88) begin
                            if (!wbs_we_i)
                                rd_d = pDATA_WIDTH'({sm_tvalid, ss_tready, xcnt_q[29:0]});
                        end
`endif
                    end
                end
            end
            LW: begin
                // Address and data channels complete independently.
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = ACK;
                    if (addr_q == LEN_OFFSET) begin
                        len_d  = wd_q;
                        xcnt_d = '0;
                    end
                end
            end
            LAR: begin
                if (arready) state_d = LR;
            end
            LR: begin
                if (rvalid) begin
                    rd_d    = rdata;
                    state_d = ACK;
                end
            end
            SSP: begin
                if (ss_tready) begin
                    if (xcnt_q != 32'hFFFF_FFFF) xcnt_d = xcnt_q + 32'd1;
                    state_d = ACK;
                end
            end
            SMP: begin
                if (sm_tvalid) begin
                    rd_d    = sm_tdata;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            rd_q      <= '0;
            len_q     <= '0;
            xcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            rd_q      <= rd_d;
            len_q     <= len_d;
            xcnt_q    <= xcnt_d;
        end
    end

    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wd_q;
    assign arvalid   = (state_q == LAR);
    assign rready    = (state_q == LR);
    assign ss_tvalid = (state_q == SSP);
    assign ss_tdata  = (state_q == SSP) ? wd_q : '0;
    assign ss_tlast  = (state_q == SSP) & last_x;
    assign sm_tready = (state_q == SMP);
    assign wbs_ack_o = (state_q == ACK);
    assign wbs_dat_o = (state_q == ACK) ? rd_q : '0;

endmodule

// File: tb/tb_wb_fir_bridge.sv
// Testbench for wb_fir_bridge: a fir model answers the AXI-Lite and stream
// sides with programmable delays; every Wishbone access pushes its expected
// read data into a scoreboard that an independent monitor pops on ack.
module tb_wb_fir_bridge;

    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        awvalid, awready, wvalid, wready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic        ss_tvalid, ss_tlast, ss_tready;
    logic [31:0] ss_tdata;
    logic        sm_tvalid, sm_tlast, sm_tready;
    logic [31:0] sm_tdata;

    wb_fir_bridge dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct { logic [31:0] data; logic last; } x_t;
    typedef struct { logic [11:0] addr; logic [31:0] data; } aw_t;

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int act_cnt = 0;

    logic [31:0] sb[$];
    x_t          x_exp[$];
    aw_t         aw_exp[$];
    logic [11:0] ar_exp[$];
    logic [31:0] y_src[$];

    // reference model state: fir registers as written, length, pushes since length write
    logic [31:0] mdl_regs [0:31];
    logic [31:0] mdl_len;
    logic [31:0] mdl_xcnt;
    // fir-side register file as actually written over AXI-Lite
    logic [31:0] fir_regs [0:31];

    int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, ss_dly = 0, sm_dly = 0;
    logic [11:0] aw_cap;
    logic [31:0] w_cap;
    bit aw_got = 0, w_got = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // bus activity on the fir side, sampled mid-cycle
    always @(negedge axis_clk)
        if (awvalid | wvalid | arvalid | rready | ss_tvalid | sm_tready) act_cnt++;

    // scoreboard monitor: every ack pops one expectation
    initial forever begin
        @(negedge axis_clk);
        if (wbs_ack_o) begin
            ack_cnt++;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL ack_unexpected: got ack data %h expected no ack", wbs_dat_o);
            end else begin
                chk("wb_rdata", wbs_dat_o, sb.pop_front());
            end
        end
    end

    // fir AW channel
    initial begin
        awready = 1'b0;
        forever begin
            @(negedge axis_clk);
            if (awvalid) begin
                repeat (aw_dly) @(negedge axis_clk);
                if (awvalid) begin
                    awready = 1'b1; aw_cap = awaddr; aw_got = 1;
                    @(negedge axis_clk);
                    awready = 1'b0;
                end
            end
        end
    end

    // fir W channel
    initial begin
        wready = 1'b0;
        forever begin
            @(negedge axis_clk);
            if (wvalid) begin
                repeat (w_dly) @(negedge axis_clk);
                if (wvalid) begin
                    wready = 1'b1; w_cap = wdata; w_got = 1;
                    @(negedge axis_clk);
                    wready = 1'b0;
                end
            end
        end
    end

    // fir register write commit once both halves arrived
    initial forever begin
        @(negedge axis_clk);
        if (aw_got && w_got) begin
            aw_t e;
            aw_got = 0; w_got = 0;
            if (aw_exp.size() == 0) begin
                checks++; failures++;
                $display("FAIL axil_write_unexpected: got addr %h expected none", aw_cap);
            end else begin
                e = aw_exp.pop_front();
                chk("awaddr", {20'd0, aw_cap}, {20'd0, e.addr});
                chk("wdata", w_cap, e.data);
            end
            fir_regs[aw_cap[6:2]] = w_cap;
        end
    end

    // fir AR/R channels
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(negedge axis_clk);
            if (arvalid) begin
                logic [11:0] a;
                repeat (ar_dly) @(negedge axis_clk);
                a = araddr;
                if (ar_exp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL axil_read_unexpected: got addr %h expected none", a);
                end else begin
                    chk("araddr", {20'd0, a}, {20'd0, ar_exp.pop_front()});
                end
                arready = 1'b1;
                @(negedge axis_clk);
                arready = 1'b0;
                chk("arvalid_drop", {31'd0, arvalid}, 32'd0);
                repeat (r_dly) @(negedge axis_clk);
                chk("rready_wait", {31'd0, rready}, 32'd1);
                rdata = fir_regs[a[6:2]]; rvalid = 1'b1;
                @(negedge axis_clk);
                rvalid = 1'b0;
            end
        end
    end

    // fir X sink: checks stability while stalled, then data and tlast
    initial begin
        ss_tready = 1'b0;
        forever begin
            @(negedge axis_clk);
            if (ss_tvalid) begin
                logic [31:0] d0;
                logic l0;
                bit ok;
                d0 = ss_tdata; l0 = ss_tlast; ok = 1;
                for (int i = 0; i < ss_dly; i++) begin
                    @(negedge axis_clk);
                    if (!ss_tvalid) begin ok = 0; break; end
                    chk("ss_tdata_stable", ss_tdata, d0);
                    chk("ss_tlast_stable", {31'd0, ss_tlast}, {31'd0, l0});
                end
                if (ok) begin
                    if (x_exp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL push_unexpected: got data %h expected none", d0);
                    end else begin
                        x_t e;
                        e = x_exp.pop_front();
                        chk("ss_tdata", d0, e.data);
                        chk("ss_tlast", {31'd0, l0}, {31'd0, e.last});
                    end
                    ss_tready = 1'b1;
                    @(negedge axis_clk);
                    ss_tready = 1'b0;
                end
            end
        end
    end

    // fir Y source
    initial begin
        sm_tvalid = 1'b0; sm_tdata = '0; sm_tlast = 1'b0;
        forever begin
            @(negedge axis_clk);
            if (sm_tready) begin
                bit ok;
                ok = 1;
                for (int i = 0; i < sm_dly; i++) begin
                    @(negedge axis_clk);
                    chk("sm_tready_hold", {31'd0, sm_tready}, 32'd1);
                    if (!sm_tready) begin ok = 0; break; end
                end
                if (ok) begin
                    if (y_src.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL pop_unexpected: got sm_tready expected none");
                        sm_tdata = 32'hDEAD_BEEF;
                    end else begin
                        sm_tdata = y_src.pop_front();
                    end
                    sm_tvalid = 1'b1;
                    @(negedge axis_clk);
                    sm_tvalid = 1'b0;
                end
            end
        end
    end

    // One Wishbone access: model predicts the outcome, then the bus is driven.
    task automatic do_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             output int lat);
        logic [31:0] exp;
        logic [7:0]  off;
        bit          quick;
        int          act0;
        x_t          xe;
        aw_t         ae;
        exp = '0; quick = 1;
        if (adr[31:8] == 24'h30_0000) begin
            off = adr[7:0];
            if (off < 8'h80) begin
                quick = 0;
                if (we) begin
                    mdl_regs[off[6:2]] = dat;
                    ae.addr = {4'd0, off}; ae.data = dat;
                    aw_exp.push_back(ae);
                    if (off == 8'h10) begin mdl_len = dat; mdl_xcnt = 0; end
                end else begin
                    ar_exp.push_back({4'd0, off});
                    exp = mdl_regs[off[6:2]];
                end
            end else if (off == 8'h80 && we) begin
                quick = 0;
                xe.data = dat;
                xe.last = (mdl_len != 0) && (mdl_xcnt + 1 == mdl_len);
                x_exp.push_back(xe);
                if (mdl_xcnt != 32'hFFFF_FFFF) mdl_xcnt++;
            end else if (off == 8'h84 && !we) begin
                quick = 0;
                y_src.push_back(dat);
                exp = dat;
            end
`ifdef WB_FIR_STATUS_EN
            else if (off == 8'h88 && !we) begin
                exp = {2'b00, mdl_xcnt[29:0]};
            end
`endif
        end
        sb.push_back(exp);
        @(negedge axis_clk);
        act0 = act_cnt;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
        lat = 0;
        do begin
            @(posedge axis_clk); #1; lat++;
        end while (!wbs_ack_o && lat < 300);
        if (!wbs_ack_o) begin
            checks++; failures++;
            $display("FAIL ack_timeout: got no ack in %0d cycles expected ack at %h", lat, adr);
        end
        if (quick) begin
            chk("quick_latency", 32'(lat), 32'd1);
            chk("quick_no_fir", 32'(act_cnt - act0), 32'd0);
        end
        @(negedge axis_clk);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        @(posedge axis_clk); #1;
        chk("ack_single", {31'd0, wbs_ack_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0, k;
        logic [31:0] adr, dat;
        logic [7:0]  o;
        for (int i = 0; i < 32; i++) begin mdl_regs[i] = '0; fir_regs[i] = '0; end
        mdl_regs[0] = 32'h4; fir_regs[0] = 32'h4;
        mdl_len = 0; mdl_xcnt = 0;
        axis_rst = 1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        wbs_sel_i = 4'hF; wbs_adr_i = '0; wbs_dat_i = '0;
        repeat (3) @(negedge axis_clk);
        chk("rst_outputs", {20'd0, wbs_ack_o, awvalid, wvalid, arvalid, rready, ss_tvalid,
                            ss_tlast, sm_tready, 4'd0}, 32'd0);
        chk("rst_dat_o", wbs_dat_o, 32'd0);
        chk("rst_ss_tdata", ss_tdata, 32'd0);
        axis_rst = 0;

        // zero-wait AXI write: ack two cycles after the request is sampled
        do_access(1, 32'h3000_0020, 32'h00A5_A5A5, lat);
        chk("min_latency", 32'(lat), 32'd2);

        // length write, awready trailing wready by three cycles
        aw_dly = 3; w_dly = 0; a0 = ack_cnt;
        do_access(1, 32'h3000_0010, 32'd64, lat);
        chk("len_write_acks", 32'(ack_cnt - a0), 32'd1);
        aw_dly = 0;

        // read with rvalid two cycles after arready
        r_dly = 2;
        do_access(0, 32'h3000_0000, 32'd0, lat);
        r_dly = 0;

        // length 3, three pushes, second one stalled
        do_access(1, 32'h3000_0010, 32'd3, lat);
        a0 = ack_cnt;
        do_access(1, 32'h3000_0080, 32'd1, lat);
        ss_dly = 4;
        do_access(1, 32'h3000_0080, 32'd2, lat);
        ss_dly = 0;
        do_access(1, 32'h3000_0080, 32'd3, lat);
        chk("push_acks", 32'(ack_cnt - a0), 32'd3);

        // Y pop with sm_tvalid five cycles late
        sm_dly = 5;
        do_access(0, 32'h3000_0084, 32'hFFFF_FFF6, lat);
        sm_dly = 0;

        // unmapped offset and foreign base
        do_access(0, 32'h3000_00FC, 32'd0, lat);
        do_access(0, 32'h3100_0000, 32'd0, lat);

        // two pushes then the status word
        do_access(1, 32'h3000_0010, 32'd2, lat);
        do_access(1, 32'h3000_0080, 32'h11, lat);
        do_access(1, 32'h3000_0080, 32'h22, lat);
        do_access(0, 32'h3000_0088, 32'd0, lat);

        // reset while a push is stalled
        ss_dly = 20;
        @(negedge axis_clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
        wbs_adr_i = 32'h3000_0080; wbs_dat_i = 32'h55;
        repeat (4) @(negedge axis_clk);
        chk("rst_pre_tvalid", {31'd0, ss_tvalid}, 32'd1);
        a0 = ack_cnt;
        axis_rst = 1;
        @(negedge axis_clk);
        chk("rst_tvalid_drop", {31'd0, ss_tvalid}, 32'd0);
        axis_rst = 0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        repeat (5) @(negedge axis_clk);
        chk("rst_no_ack", 32'(ack_cnt - a0), 32'd0);
        ss_dly = 0;
        mdl_len = 0; mdl_xcnt = 0;
        do_access(0, 32'h3000_0088, 32'd0, lat);
        do_access(1, 32'h3000_0080, 32'h77, lat);
        do_access(1, 32'h3000_0080, 32'h78, lat);

        // randomized traffic
        for (int n = 0; n < 160; n++) begin
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
            ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 4);
            ss_dly = $urandom_range(0, 4); sm_dly = $urandom_range(0, 4);
            k = $urandom_range(0, 9);
            o = {1'b0, 5'($urandom_range(0, 31)), 2'b00};
            dat = $urandom;
            case (k)
                0, 1: begin
                    if (o == 8'h10) dat = 32'($urandom_range(0, 5));
                    do_access(1, {24'h30_0000, o}, dat, lat);
                end
                2, 3: do_access(0, {24'h30_0000, o}, dat, lat);
                4, 5: do_access(1, 32'h3000_0080, dat, lat);
                6:    do_access(0, 32'h3000_0084, dat, lat);
                7: begin
                    case ($urandom_range(0, 2))
                        0: adr = {24'h30_0000, 8'(8'h8C + 4 * $urandom_range(0, 28))};
                        1: begin
                            adr = $urandom;
                            if (adr[31:8] == 24'h30_0000) adr[31] = 1'b1;
                        end
                        default: adr = 32'h3000_0088;
                    endcase
                    do_access($urandom_range(0, 1) == 1, adr, dat, lat);
                end
                8: begin
                    if ($urandom_range(0, 1) == 1) do_access(1, 32'h3000_0084, dat, lat);
                    else do_access(0, 32'h3000_0080, dat, lat);
                end
                default: do_access(1, 32'h3000_0010, 32'($urandom_range(1, 4)), lat);
            endcase
        end

        repeat (10) @(negedge axis_clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("x_exp_empty", 32'(x_exp.size()), 32'd0);
        chk("aw_exp_empty", 32'(aw_exp.size()), 32'd0);
        chk("ar_exp_empty", 32'(ar_exp.size()), 32'd0);
        chk("y_src_empty", 32'(y_src.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
